lab_g_debouncer: RTL and testbench
==================================

LAB_G_DEBOUNCER -- requirements
Module: lab_g_debouncer

Interface
- REQ-001: The block SHALL have parameter DB_CYCLES, default 4: consecutive stable synchronized samples required before dout changes; legal range 1 to 2^CNT_W-1.
- REQ-002: The block SHALL have parameter CNT_W, default 16: width of the stability counter in bits.
- REQ-003: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004: The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-005: The block SHALL have port din, input, 1 bit: raw asynchronous switch or button level.
- REQ-006: The block SHALL have port dout, output, 1 bit: debounced registered level, driving the downstream D flip-flop D input.
- REQ-007: The block SHALL have port rise, output, 1 bit: one-cycle pulse when dout goes 0->1.
- REQ-008: The block SHALL have port fall, output, 1 bit: one-cycle pulse when dout goes 1->0.
- REQ-009: The block SHALL have port busy, output, 1 bit: high while a candidate transition is being qualified (WAIT states).

Function
- REQ-010: din SHALL pass through a two-flop synchronizer (s1 <= din, s2 <= s1); only s2 SHALL be used by the control logic.
- REQ-011: The FSM SHALL have exactly four states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW; dout SHALL be 1 only in IDLE_HIGH and WAIT_LOW.
- REQ-012: IDLE_LOW with s2=1 SHALL go to WAIT_HIGH with cnt <= 1; IDLE_HIGH with s2=0 SHALL go to WAIT_LOW with cnt <= 1; otherwise IDLE states hold with cnt = 0.
- REQ-013: In WAIT_HIGH, s2=0 SHALL return to IDLE_LOW, cnt <= 0, no pulse; likewise in WAIT_LOW, s2=1 SHALL return to IDLE_HIGH, cnt <= 0, no pulse.
- REQ-014: In a WAIT state with s2 still at the candidate level, cnt SHALL increment by 1 while cnt < DB_CYCLES; when cnt = DB_CYCLES, the next edge SHALL enter the opposite IDLE state, toggle dout, clear cnt, and pulse rise or fall.
- REQ-015: Latency: with din changed before rising edge 1 and held, dout SHALL change at edge DB_CYCLES+3 (edge 7 at default).
- REQ-016: rise and fall SHALL be registered, high for exactly one clock, and never high simultaneously.
- REQ-017: busy SHALL be a registered decode of WAIT_HIGH or WAIT_LOW.
- REQ-018: cnt SHALL never exceed DB_CYCLES and SHALL never wrap.
- REQ-019: Unused state encodings SHALL recover to IDLE_LOW on the next edge with dout=0 and no pulse.

Reset
- REQ-020: While rst=1 at a rising edge, s1, s2, cnt, dout, rise, fall and busy SHALL be 0 and the state SHALL be IDLE_LOW, regardless of din.
- REQ-021: rst SHALL take priority over all transitions; reset asserted during a WAIT state SHALL abort qualification with no pulse emitted.
- REQ-022: After rst deasserts with din=1 held, the block SHALL qualify a rising transition normally (dout=1 at edge DB_CYCLES+3 after release).

Configuration
- REQ-023: Macro LAB_G_DEBOUNCER_PULSE_EN defined: rise and fall SHALL behave per REQ-007, REQ-008, REQ-014 and REQ-016.
- REQ-024: Macro LAB_G_DEBOUNCER_PULSE_EN undefined: the pulse registers SHALL be omitted and rise and fall tied to 0; dout, busy and latency SHALL be unchanged.

Verification
- REQ-025: rst=1 for 2 cycles, din=0; din 0->1 at t before edge 1, held -> dout=1 at edge 7, rise=1 for exactly that cycle, busy=1 on edges 3-6.
- REQ-026: dout=1 idle; din=0 for 2 cycles, then back to 1 -> dout stays 1, fall never asserts, busy returns to 0.
- REQ-027: dout=1 idle; din 1->0 held -> dout=0 at edge 7, fall one-cycle pulse, rise stays 0.
- REQ-028: din toggled every 3 cycles for 40 cycles -> dout never changes, no pulses, cnt never exceeds 4.
- REQ-029: rst asserted at edge 5 of a rising qualification -> dout=0, busy=0, no rise pulse; after release with din=1 held, dout=1 at edge 7.
- REQ-030: Build without LAB_G_DEBOUNCER_PULSE_EN and rerun REQ-025 -> dout timing identical, rise and fall constantly 0.

Source files
------------

// File: rtl/lab_g_debouncer.sv
// Switch/button debouncer: two-flop synchronizer, four-state qualification FSM, registered level and edge pulses.
// Build option: define LAB_G_DEBOUNCER_PULSE_EN to generate rise/fall pulses; otherwise both are tied low.
module lab_g_debouncer #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  // state     | meaning
  // IDLE_LOW  | dout=0, synchronized input agrees
  // WAIT_HIGH | dout=0, input high, counting stable samples
  // IDLE_HIGH | dout=1, synchronized input agrees
  // WAIT_LOW  | dout=1, input low, counting stable samples
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DB_C = CNT_W'(DB_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s2_q)             state_d = IDLE_LOW;
        else if (cnt_q >= DB_C) state_d = IDLE_HIGH;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      IDLE_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s2_q)              state_d = IDLE_HIGH;
        else if (cnt_q >= DB_C) state_d = IDLE_LOW;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE_LOW;
    endcase
    dout_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

`ifdef LAB_G_DEBOUNCER_PULSE_EN
  logic rise_q, fall_q;
  logic rise_d, fall_d;

  // A pulse marks only the completed qualification, never an aborted one.
  assign rise_d = (state_q == WAIT_HIGH) && (state_d == IDLE_HIGH);
  assign fall_d = (state_q == WAIT_LOW)  && (state_d == IDLE_LOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

  assign dout = dout_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_lab_g_debouncer.sv
// Self-checking bench for lab_g_debouncer: directed latency/glitch/reset scenarios plus random stimulus
// compared against a run-length reference model.
module tb_lab_g_debouncer;
  localparam int DB = 4;
`ifdef LAB_G_DEBOUNCER_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, rise, fall, busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: input delayed two edges, dout flips once the delayed input
  // has disagreed with dout for more than DB consecutive edges.
  bit m_s1, m_s2, m_dout, m_rise, m_fall;
  int m_run;

  lab_g_debouncer #(.DB_CYCLES(DB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .din(din),
    .dout(dout), .rise(rise), .fall(fall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0; m_run = 0;
    end else begin
      if (m_s2 != m_dout) begin
        m_run++;
        if (m_run > DB) begin
          m_dout = !m_dout;
          m_run  = 0;
          if (PULSE) begin
            if (m_dout) m_rise = 1'b1;
            else        m_fall = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = din;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = i[0];
      step();
      n_checks++;
      if ({dout, busy, rise, fall} !== 4'b0000)
        $display("FAIL reset cyc %0d: got dout/busy/rise/fall=%b required 0000", i, {dout, busy, rise, fall});
      else n_pass++;
    end
  endtask

  task automatic test_rise_latency();
    logic [3:0] exp;
    rst = 1'b1; din = 1'b0;
    step(); step();
    rst = 1'b0; din = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp = {e >= 7, (e >= 3 && e <= 6), PULSE && (e == 7), 1'b0};
      n_checks++;
      if ({dout, busy, rise, fall} !== exp)
        $display("FAIL rise_latency edge %0d: got dout/busy/rise/fall=%b required %b", e, {dout, busy, rise, fall}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_glitch_high();
    for (int e = 1; e <= 10; e++) begin
      din = (e <= 2) ? 1'b0 : 1'b1;
      step();
      n_checks++;
      if (dout !== 1'b1 || fall !== 1'b0 || rise !== 1'b0)
        $display("FAIL glitch_high edge %0d: got dout/rise/fall=%b%b%b required 100", e, dout, rise, fall);
      else n_pass++;
      n_checks++;
      if (busy !== (m_run > 0))
        $display("FAIL glitch_busy edge %0d: got busy=%b required %b", e, busy, m_run > 0);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL glitch_busy_end: got busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_fall();
    logic [3:0] exp;
    din = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp = {e < 7, (e >= 3 && e <= 6), 1'b0, PULSE && (e == 7)};
      n_checks++;
      if ({dout, busy, rise, fall} !== exp)
        $display("FAIL fall edge %0d: got dout/busy/rise/fall=%b required %b", e, {dout, busy, rise, fall}, exp);
      else n_pass++;
    end
  endtask

  task automatic test_toggle3();
    logic d0;
    d0 = dout;
    for (int i = 0; i < 40; i++) begin
      din = ((i / 3) % 2 == 0) ? 1'b1 : 1'b0;
      step();
      n_checks++;
      if (dout !== d0 || rise !== 1'b0 || fall !== 1'b0 || dut.cnt_q > 16'(DB))
        $display("FAIL toggle3 cyc %0d: got dout=%b rise=%b fall=%b cnt=%0d required dout=%b no pulse cnt<=%0d",
                 i, dout, rise, fall, dut.cnt_q, d0, DB);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    din = 1'b0;
    repeat (6) step();
    din = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({dout, busy, rise, fall} !== 4'b0000)
      $display("FAIL reset_abort: got dout/busy/rise/fall=%b required 0000", {dout, busy, rise, fall});
    else n_pass++;
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_checks++;
      if (dout !== (e >= 7) || rise !== (PULSE && e == 7))
        $display("FAIL reset_release edge %0d: got dout=%b rise=%b required %b %b", e, dout, rise, e >= 7, PULSE && e == 7);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) din = !din;
      rst = ($urandom_range(299) == 0);
      step();
      n_checks++;
      if ({dout, busy, rise, fall} !== {m_dout, m_run > 0, m_rise, m_fall} || (rise && fall))
        $display("FAIL random cyc %0d: got dout/busy/rise/fall=%b required %b", i,
                 {dout, busy, rise, fall}, {m_dout, m_run > 0, m_rise, m_fall});
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch_high();
    test_fall();
    test_toggle3();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
